// File: rtl/arbiter_pkg.sv
// Shared types for the four-phase arbiter: FSM state encoding and default channel count.
// Pure declarations, no logic, no latency, no flow control.
package arbiter_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK,
    REL
  } arb_state_t;

endpackage

// File: rtl/arbiter_rr_nb_rr_pick.sv
// rr_pick: combinational first-set search over req starting at ptr and wrapping N-1 -> 0.
// Zero latency; no flow control, valid=0 when no request is pending.
module rr_pick #(
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  always_comb begin
    int c;
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!valid && req[c]) begin
        valid = 1'b1;
        idx   = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/arbiter_rr_nb.sv
// N-channel four-phase req/ack arbiter, registered outputs, grant 1 cycle after a request is seen in IDLE.
// Backpressure: holds the grant until downstream acks and the winner releases; ARB_RR_EN selects round-robin, else fixed priority.
module arbiter_rr_nb
  import arbiter_pkg::*;
#(
  parameter  int N     = N_DEFAULT,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_in,
  output logic [N-1:0]     ack_in,
  output logic             req_out,
  input  logic             ack_out,
  output logic [SEL_W-1:0] sel
);

  arb_state_t       state, state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [N-1:0]     ack_nxt;
  logic             req_nxt;
  logic [SEL_W-1:0] ptr;
  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;

`ifdef ARB_RR_EN
  logic [SEL_W-1:0] ptr_nxt;
`else
  assign ptr = '0;
`endif

  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req   (req_in),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ack_nxt   = ack_in;
    req_nxt   = req_out;
`ifdef ARB_RR_EN
    ptr_nxt   = ptr;
`endif
    case (state)
      IDLE: if (pick_valid) begin
        sel_nxt   = pick_idx;
        req_nxt   = 1'b1;
        state_nxt = REQ;
      end
      REQ: if (ack_out) begin
        ack_nxt      = '0;
        ack_nxt[sel] = 1'b1;
        state_nxt    = ACK;
      end
      ACK: if (!req_in[sel]) begin
        ack_nxt   = '0;
        req_nxt   = 1'b0;
        state_nxt = REL;
      end
      REL: if (!ack_out) begin
`ifdef ARB_RR_EN
        ptr_nxt   = (sel == SEL_W'(N - 1)) ? '0 : sel + SEL_W'(1);
`endif
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      ack_in  <= '0;
      req_out <= 1'b0;
`ifdef ARB_RR_EN
      ptr     <= '0;
`endif
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      ack_in  <= ack_nxt;
      req_out <= req_nxt;
`ifdef ARB_RR_EN
      ptr     <= ptr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_arbiter_rr_nb.sv
// Directed bench for arbiter_rr_nb with a grant scoreboard; expectations follow ARB_RR_EN.
module tb_arbiter_rr_nb;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_in;
  logic [N-1:0] ack_in;
  logic         req_out;
  logic         ack_out;
  logic [1:0]   sel;

  int vectors     = 0;
  int miscompares = 0;
  int exp_q[$];

  arbiter_rr_nb #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_in  (req_in),
    .ack_in  (ack_in),
    .req_out (req_out),
    .ack_out (ack_out),
    .sel     (sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full handshake: the winner drops only its own bit, the other mask bits stay up.
  task automatic hs(input logic [N-1:0] mask, input int exp_sel, input string tag);
    int waited;
    int e;
    exp_q.push_back(exp_sel);
    req_in = mask;
    waited = 0;
    while (!req_out && waited < 10) begin
      tick();
      waited++;
    end
    chk({tag, "_grant_lat"}, 32'(waited), 32'd1);
    e = exp_q.pop_front();
    chk({tag, "_sel"}, 32'(sel), 32'(e));
    ack_out = 1'b1;
    tick();
    chk({tag, "_ack_in"}, 32'(ack_in), 32'(1 << e));
    req_in[e] = 1'b0;
    tick();
    chk({tag, "_release"}, {30'b0, req_out, |ack_in}, 32'd0);
    chk({tag, "_sel_hold"}, 32'(sel), 32'(e));
    ack_out = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rr_exp[5];
`ifdef ARB_RR_EN
    rr_exp = '{0, 1, 2, 3, 0};
`else
    rr_exp = '{0, 0, 0, 0, 0};
`endif
    rst = 1'b1; req_in = 4'b1111; ack_out = 1'b1;
    tick(); tick();
    chk("reset_ack_in", 32'(ack_in), 32'd0);
    chk("reset_req_out", 32'(req_out), 32'd0);
    chk("reset_sel", 32'(sel), 32'd0);
    rst = 1'b0; req_in = '0; ack_out = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) hs(4'b1111, rr_exp[i], $sformatf("rr%0d", i));
    req_in = '0;
    tick();

    hs(4'b0100, 2, "single");

    hs(4'b0011, 0, "wrap0");
    hs(4'b0010, 1, "skip1");

    // Late arrival on channel 0 while channel 1 holds the grant
    req_in = 4'b0010;
    tick();
    chk("late_sel", 32'(sel), 32'd1);
    req_in[0] = 1'b1;
    ack_out = 1'b1;
    tick();
    chk("late_ack_in", 32'(ack_in), 32'b0010);
    chk("late_sel_hold", 32'(sel), 32'd1);
    req_in[1] = 1'b0;
    tick();
    chk("late_release", 32'(ack_in), 32'd0);
    ack_out = 1'b0;
    tick();
    hs(4'b0001, 0, "late_next");

    // Reset while in ACK
    req_in = 4'b0100;
    tick();
    ack_out = 1'b1;
    tick();
    chk("mid_ack_in", 32'(ack_in), 32'b0100);
    rst = 1'b1;
    tick();
    chk("mid_rst_ack_in", 32'(ack_in), 32'd0);
    chk("mid_rst_req_out", 32'(req_out), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    rst = 1'b0; req_in = '0; ack_out = 1'b0;
    tick();
    hs(4'b1000, 3, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
